board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Owns the single access port of the Minesweeper board-state BlockRAM (one 32-bit word per tile).
- Shares that port between the processor data path (read/write) and the VGA tile fetcher (read-only).
- Also runs a hardware board-clear sequence for new games.
- Sits between those requesters and the RAM, and is the only driver of the RAM port.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, RAM data width.
- NUM_TILES, 256, number of consecutive words cleared by the clear engine, starting at CLR_BASE.
- CLR_BASE, 0, first address written by the clear engine.
- CLEAR_VAL, 0, word written to every tile during a clear.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr_start  in  1  one-cycle pulse that starts a board clear.
- clr_busy  out  1  high while a clear is in progress.
- clr_done  out  1  one-cycle pulse after the final clear write.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; held stable with cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid during cpu_ack, held afterwards.
- vga_req  in  1  VGA read request; held high until vga_ack.
- vga_addr  in  ADDR_W  VGA word address.
- vga_ack  out  1  one-cycle completion pulse.
- vga_rdata  out  DATA_W  read data; valid during vga_ack, held afterwards.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_dataIn  out  DATA_W  RAM write data.
- ram_dataOut  in  DATA_W  RAM synchronous read data, valid the cycle after the address edge.

Behaviour:
- Reset (reset low), asynchronous:
  - clr_busy, clr_done, cpu_ack and vga_ack go to 0.
  - cpu_rdata and vga_rdata go to 0; clear counter goes to 0; last_grant goes to CPU.
  - ram_wEn is forced to 0 combinationally for as long as reset is low.
  - Any in-flight access is dropped and never acked; requesters re-issue it after reset.
- Grant (combinational, cycle N): exactly one of CLEAR, VGA, CPU, NONE.
  - CLEAR whenever clr_busy = 1; CPU and VGA are stalled with no grant and no ack.
  - Otherwise a requester is eligible when req = 1 and its own ack = 0 in cycle N. The ack-cycle exclusion prevents a double grant before req drops.
  - One eligible requester is granted.
  - Both eligible: grant goes to the one not equal to last_grant (round-robin). The first tie after reset goes to VGA.
  - last_grant updates on every CPU or VGA grant.
- RAM drive in cycle N (combinational from the grant):
  - CLEAR: ram_addr = CLR_BASE + count, ram_dataIn = CLEAR_VAL, ram_wEn = 1.
  - CPU: ram_addr = cpu_addr, ram_dataIn = cpu_wdata, ram_wEn = cpu_we.
  - VGA: ram_addr = vga_addr, ram_wEn = 0.
  - NONE: ram_wEn = 0; ram_addr holds its previous value.
  - ram_dataIn is don't-care when ram_wEn = 0.
- Completion: a requester granted in cycle N sees its ack = 1 in cycle N+1 only (latency 1).
  - During the ack cycle of a read, xxx_rdata = ram_dataOut (live). The value is captured at the end of N+1 and held until the next read ack for that port.
  - CPU writes do not alter cpu_rdata.
- Throughput:
  - A single requester can be served at most once every 2 cycles.
  - With both requesters interleaved, the RAM is busy every cycle.
- Clear FSM (IDLE, CLEARING):
  - IDLE: clr_start = 1 moves to CLEARING at the next edge with clr_busy = 1 and count = 0.
  - A clr_start pulse while CLEARING is ignored.
  - CLEARING: one write per cycle, count += 1.
  - After the write with count = NUM_TILES-1, return to IDLE. clr_busy drops and clr_done = 1 for that one cycle.
  - Total is exactly NUM_TILES busy cycles.
  - An access granted in the cycle before CLEARING begins still completes and acks normally during the first clear cycle.
- Simultaneous clr_start with a CPU/VGA request in IDLE: the request is granted that cycle (the clear has not yet started); the clear starts next cycle.
- Address arithmetic: CLR_BASE + count is truncated to ADDR_W; no range checking on requester addresses.

Test Plan:
- Reset: drive reset low mid CPU write with cpu_req=1 → cpu_ack=0, cpu_rdata=0, ram_wEn=0 while reset is low; the write is not acked after release until re-requested.
- Single CPU: write 0x0000_0009 to addr 0x005, then read 0x005 → ack 1 cycle after each grant; cpu_rdata=0x0000_0009 in the read ack cycle and held after.
- Contention: cpu_req and vga_req held high continuously after reset → grants alternate VGA, CPU, VGA, … every cycle; each side acked every 2nd cycle; no double grant during an ack cycle.
- Clear: NUM_TILES=256, pre-write 0xFF at addr 0x000 and 0x0FF, pulse clr_start → clr_busy high exactly 256 cycles; writes to addr 0x000–0x0FF in order; clr_done pulses once. Subsequent reads of 0x000 and 0x0FF return 0; vga_req during the clear is acked only after clr_busy falls.
- Edge: clr_start re-pulsed at count=100 → ignored, still 256 writes total. clr_start coincident with cpu_req in IDLE → CPU granted first and acked in the first clearing cycle.
- Reset during a clear at count=50 → clr_busy=0 immediately, no clr_done; a fresh clr_start restarts from count 0.

Source files
------------

// File: rtl/board_ram_arbiter.sv
// Sole driver of the board-state BlockRAM port: shares it between CPU and VGA
// requesters (round-robin on ties) and runs the hardware board-clear sequence.
module board_ram_arbiter #(
  parameter int              ADDR_W    = 12,
  parameter int              DATA_W    = 32,
  parameter int              NUM_TILES = 256,
  parameter int              CLR_BASE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam int CNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_CPU   = 2'd1,
    GRANT_VGA   = 2'd2,
    GRANT_CLEAR = 2'd3
  } grant_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } clr_state_e;

  grant_e            grant_s;
  logic              cpu_elig_s;
  logic              vga_elig_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_din_s;
  logic              ram_we_s;

  clr_state_e        clr_state_r;
  logic [CNT_W-1:0]  clr_cnt_r;
  logic              clr_busy_r;
  logic              clr_done_r;
  logic              cpu_ack_r;
  logic              cpu_rd_r;
  logic              vga_ack_r;
  logic              last_vga_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] vga_rdata_r;

  // A requester in its ack cycle is not eligible, so a still-high req cannot be granted twice.
  assign cpu_elig_s = cpu_req & ~cpu_ack_r;
  assign vga_elig_s = vga_req & ~vga_ack_r;
  assign clr_addr_s = ADDR_W'(CLR_BASE) + ADDR_W'(clr_cnt_r);

  // Grant selection: clear engine first, then round-robin between CPU and VGA.
  always_comb begin
    grant_s = GRANT_NONE;
    if (clr_busy_r) begin
      grant_s = GRANT_CLEAR;
    end else if (cpu_elig_s && vga_elig_s) begin
      grant_s = last_vga_r ? GRANT_CPU : GRANT_VGA;
    end else if (vga_elig_s) begin
      grant_s = GRANT_VGA;
    end else if (cpu_elig_s) begin
      grant_s = GRANT_CPU;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // RAM port drive from the current grant; the address parks on its last value when idle.
  always_comb begin
    ram_addr_s = addr_hold_r;
    ram_din_s  = '0;
    ram_we_s   = 1'b0;
    case (grant_s)
      GRANT_CLEAR: begin
        ram_addr_s = clr_addr_s;
        ram_din_s  = CLEAR_VAL;
        ram_we_s   = 1'b1;
      end
      GRANT_CPU: begin
        ram_addr_s = cpu_addr;
        ram_din_s  = cpu_wdata;
        ram_we_s   = cpu_we;
      end
      GRANT_VGA: begin
        ram_addr_s = vga_addr;
      end
      default: begin
        ram_addr_s = addr_hold_r;
      end
    endcase
  end

  assign ram_wEn    = ram_we_s & reset;
  assign ram_addr   = ram_addr_s;
  assign ram_dataIn = ram_din_s;

  // Read data is live from the RAM during a read ack and held from a capture register otherwise.
  assign cpu_rdata = (cpu_ack_r && cpu_rd_r) ? ram_dataOut : cpu_rdata_r;
  assign vga_rdata = vga_ack_r ? ram_dataOut : vga_rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign vga_ack   = vga_ack_r;
  assign clr_busy  = clr_busy_r;
  assign clr_done  = clr_done_r;

  // Access completion, round-robin history and read-data capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_ack_r   <= 1'b0;
      cpu_rd_r    <= 1'b0;
      vga_ack_r   <= 1'b0;
      last_vga_r  <= 1'b0;
      addr_hold_r <= '0;
      cpu_rdata_r <= '0;
      vga_rdata_r <= '0;
    end else begin
      cpu_ack_r   <= (grant_s == GRANT_CPU);
      cpu_rd_r    <= (grant_s == GRANT_CPU) && !cpu_we;
      vga_ack_r   <= (grant_s == GRANT_VGA);
      addr_hold_r <= ram_addr_s;
      if (grant_s == GRANT_CPU) begin
        last_vga_r <= 1'b0;
      end else if (grant_s == GRANT_VGA) begin
        last_vga_r <= 1'b1;
      end
      if (cpu_ack_r && cpu_rd_r) begin
        cpu_rdata_r <= ram_dataOut;
      end
      if (vga_ack_r) begin
        vga_rdata_r <= ram_dataOut;
      end
    end
  end

  // Board-clear FSM: one write per cycle for NUM_TILES cycles, done pulse on exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_state_r <= ST_IDLE;
      clr_cnt_r   <= '0;
      clr_busy_r  <= 1'b0;
      clr_done_r  <= 1'b0;
    end else begin
      case (clr_state_r)
        ST_IDLE: begin
          clr_done_r <= 1'b0;
          if (clr_start) begin
            clr_state_r <= ST_CLEARING;
            clr_cnt_r   <= '0;
            clr_busy_r  <= 1'b1;
          end
        end
        ST_CLEARING: begin
          if (clr_cnt_r == LAST_CNT) begin
            clr_state_r <= ST_IDLE;
            clr_cnt_r   <= '0;
            clr_busy_r  <= 1'b0;
            clr_done_r  <= 1'b1;
          end else begin
            clr_cnt_r  <= clr_cnt_r + CNT_W'(1);
            clr_done_r <= 1'b0;
          end
        end
        default: begin
          clr_state_r <= ST_IDLE;
          clr_cnt_r   <= '0;
          clr_busy_r  <= 1'b0;
          clr_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: behavioural RAM, expected-response queues per port,
// directed reset/contention/clear scenarios and randomized CPU/VGA traffic.
module tb_board_ram_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int NUM_TILES = 256;
  localparam int CLR_BASE  = 0;
  localparam int DEPTH     = 4096;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              clr_start = 1'b0;
  logic              clr_busy, clr_done;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic              ram_wEn;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIn;
  logic [DATA_W-1:0] ram_dataOut;

  always #5 clock = ~clock;

  board_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TILES(NUM_TILES),
    .CLR_BASE(CLR_BASE), .CLEAR_VAL(32'h0000_0000)
  ) dut (
    .clock(clock), .reset(reset),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // Synchronous-read RAM the arbiter drives.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_word(i);
    ram_dataOut = '0;
    forever begin
      @(posedge clock);
      ram_dataOut <= ram_mem[ram_addr];
      if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
    end
  end

  typedef struct { bit is_rd; logic [31:0] data; } exp_t;
  exp_t        cpu_q[$];
  logic [31:0] vga_q[$];
  logic [31:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop the expected response on each ack, otherwise read data must hold.
  initial begin
    logic [31:0] cpu_hold, vga_hold;
    exp_t e;
    cpu_hold = '0;
    vga_hold = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        cpu_hold = '0;
        vga_hold = '0;
      end else begin
        if (cpu_ack) begin
          chk("cpu_ack_pending", 32'(cpu_q.size() > 0), 32'd1);
          if (cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            if (e.is_rd) begin
              chk("cpu_rdata", cpu_rdata, e.data);
              cpu_hold = e.data;
            end else begin
              chk("cpu_rdata_on_write", cpu_rdata, cpu_hold);
            end
          end
        end else begin
          chk("cpu_rdata_held", cpu_rdata, cpu_hold);
        end
        if (vga_ack) begin
          chk("vga_ack_pending", 32'(vga_q.size() > 0), 32'd1);
          if (vga_q.size() > 0) begin
            vga_hold = vga_q.pop_front();
            chk("vga_rdata", vga_rdata, vga_hold);
          end
        end else begin
          chk("vga_rdata_held", vga_rdata, vga_hold);
        end
      end
    end
  end

  task automatic cpu_txn(input bit we, input logic [11:0] addr, input logic [31:0] wd, output int lat);
    exp_t e;
    if (we) begin
      model_mem[addr] = wd;
      e.is_rd = 1'b0; e.data = wd;
    end else begin
      e.is_rd = 1'b1; e.data = model_mem[addr];
    end
    cpu_q.push_back(e);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!cpu_ack && lat < 64);
    chk("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
  endtask

  task automatic vga_txn(input logic [11:0] addr, output int lat);
    vga_q.push_back(model_mem[addr]);
    vga_addr = addr; vga_req = 1'b1;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!vga_ack && lat < 64);
    chk("vga_ack_timeout", 32'(vga_ack), 32'd1);
    vga_req = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b0;
    cpu_q.delete(); vga_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Runs one clear; optional re-pulse, coincident CPU read, VGA stall, or reset abort.
  task automatic clear_run(input int repulse_at, input bit with_cpu, input bit with_vga, input int abort_at);
    exp_t e;
    int   idx;
    int   zero_n;
    zero_n = (abort_at >= 0) ? abort_at : NUM_TILES;
    clr_start = 1'b1;
    if (with_cpu) begin
      e.is_rd = 1'b1; e.data = model_mem[12'h300];
      cpu_q.push_back(e);
      cpu_we = 1'b0; cpu_addr = 12'h300; cpu_req = 1'b1;
    end
    for (int i = 0; i < zero_n; i++) model_mem[(CLR_BASE + i) % DEPTH] = 32'h0000_0000;
    @(negedge clock);
    clr_start = 1'b0;
    if (with_cpu) begin
      chk("coincident_cpu_ack", 32'(cpu_ack), 32'd1);
      chk("coincident_clr_busy", 32'(clr_busy), 32'd1);
      cpu_req = 1'b0;
    end
    idx = 0;
    for (int guard = 0; guard < NUM_TILES + 20; guard++) begin
      if (!clr_busy) break;
      if (idx == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_busy_drop", 32'(clr_busy), 32'd0);
        chk("abort_wen_low", 32'(ram_wEn), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        cpu_q.delete(); vga_q.delete();
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          chk("abort_no_done", 32'(clr_done), 32'd0);
          chk("abort_idle", 32'(clr_busy), 32'd0);
        end
        return;
      end
      chk("clr_wen", 32'(ram_wEn), 32'd1);
      chk("clr_addr", 32'(ram_addr), 32'((CLR_BASE + idx) % DEPTH));
      chk("clr_data", ram_dataIn, 32'h0000_0000);
      clr_start = (idx == repulse_at);
      if (with_vga && idx == 10) begin
        vga_q.push_back(model_mem[12'h0FF]);
        vga_addr = 12'h0FF; vga_req = 1'b1;
      end
      if (with_vga && idx >= 10) chk("clr_vga_stalled", 32'(vga_ack), 32'd0);
      idx++;
      @(negedge clock);
    end
    clr_start = 1'b0;
    chk("clr_busy_cycles", 32'(idx), 32'(NUM_TILES));
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    @(negedge clock);
    if (with_vga) begin
      chk("vga_after_clear", 32'(vga_ack), 32'd1);
      vga_req = 1'b0;
    end
    chk("clr_done_once", 32'(clr_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nv, nc;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_vga_ack", 32'(vga_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_vga_rdata", vga_rdata, 32'd0);
    chk("rst_wen", 32'(ram_wEn), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Single CPU write then read, latency 1 from an idle arbiter
    cpu_txn(1'b1, 12'h005, 32'h0000_0009, lat);
    chk("cpu_write_latency", 32'(lat), 32'd1);
    @(negedge clock);
    cpu_txn(1'b0, 12'h005, 32'h0, lat);
    chk("cpu_read_latency", 32'(lat), 32'd1);
    repeat (2) @(negedge clock);

    // Reset in the middle of a CPU write: dropped, never acked, RAM untouched
    cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 32'hDEAD_BEEF; cpu_req = 1'b1;
    reset = 1'b0;
    #1;
    chk("rstw_wen", 32'(ram_wEn), 32'd0);
    chk("rstw_rdata", cpu_rdata, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("rstw_ack", 32'(cpu_ack), 32'd0);
      chk("rstw_wen_hold", 32'(ram_wEn), 32'd0);
      chk("rstw_rdata_hold", cpu_rdata, 32'd0);
    end
    cpu_req = 1'b0;
    cpu_q.delete(); vga_q.delete();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("rstw_no_late_ack", 32'(cpu_ack), 32'd0);
    end
    cpu_txn(1'b0, 12'h005, 32'h0, lat);
    @(negedge clock);

    // Contention after reset: VGA wins first tie, then strict alternation
    reset_pulse();
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e.is_rd = 1'b1; e.data = model_mem[12'h123];
      cpu_q.push_back(e);
      vga_q.push_back(model_mem[12'h923]);
    end
    cpu_we = 1'b0; cpu_addr = 12'h123; vga_addr = 12'h923;
    cpu_req = 1'b1; vga_req = 1'b1;
    nv = 0; nc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      chk("contend_vga_ack", 32'(vga_ack), 32'(k % 2));
      chk("contend_cpu_ack", 32'(cpu_ack), 32'((k + 1) % 2));
      if (vga_ack) nv++;
      if (cpu_ack) nc++;
      if (nv == 6) vga_req = 1'b0;
      if (nc == 6) cpu_req = 1'b0;
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    @(negedge clock);
    chk("contend_quiet_vga", 32'(vga_ack), 32'd0);
    chk("contend_quiet_cpu", 32'(cpu_ack), 32'd0);

    // Clear with pre-written corners and a VGA read stalled behind it
    cpu_txn(1'b1, 12'h000, 32'h0000_00FF, lat);
    cpu_txn(1'b1, 12'h0FF, 32'h0000_00FF, lat);
    @(negedge clock);
    clear_run(-1, 1'b0, 1'b1, -1);
    cpu_txn(1'b0, 12'h000, 32'h0, lat);
    cpu_txn(1'b0, 12'h0FF, 32'h0, lat);
    @(negedge clock);

    // Re-pulse at count 100 ignored; clr_start coincident with a CPU read
    cpu_txn(1'b1, 12'h040, 32'h1357_9BDF, lat);
    @(negedge clock);
    clear_run(100, 1'b1, 1'b0, -1);
    cpu_txn(1'b0, 12'h040, 32'h0, lat);
    @(negedge clock);

    // Reset during a clear at count 50, then a fresh full clear
    clear_run(-1, 1'b0, 1'b0, 50);
    clear_run(-1, 1'b0, 1'b0, -1);

    // Random CPU-only traffic across the whole address space
    for (int k = 0; k < 30; k++) begin
      cpu_txn(1'($urandom_range(0, 1)), 12'($urandom_range(0, DEPTH - 1)), $urandom, lat);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Random concurrent traffic: CPU in the lower half, VGA reads in the upper half
    fork
      begin
        int l1;
        for (int k = 0; k < 40; k++) begin
          cpu_txn(1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'h7FF)), $urandom, l1);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
      begin
        int l2;
        for (int k = 0; k < 40; k++) begin
          vga_txn(12'($urandom_range(12'h800, 12'hFFF)), l2);
          repeat ($urandom_range(0, 2)) @(negedge clock);
        end
      end
    join
    repeat (3) @(negedge clock);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    chk("vga_queue_drained", 32'(vga_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
